// File: rtl/dial_cmd_sequencer_if.sv
// Signal bundle between the dial command sequencer and its surroundings:
// the command beat stream, the rotation core, the result nibble stream and status.
interface dial_cmd_sequencer_if #(
    parameter int INPUT_WIDTH = 4
);
    logic [INPUT_WIDTH-1:0] in_data;
    logic                   in_dir_r;
    logic                   in_last;
    logic                   in_valid;
    logic                   in_ready;

    logic [31:0]            core_data;
    logic                   core_dir_r;
    logic                   core_step;
    logic                   core_clr;
    logic [31:0]            core_zero_count;

    logic [3:0]             out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;

    logic [15:0]            cmd_count;
    logic                   err;

    // master: the sequencer itself; slave: the beat source, core and result sink
    modport master (
        input  in_data, in_dir_r, in_last, in_valid, core_zero_count, out_ready,
        output in_ready, core_data, core_dir_r, core_step, core_clr,
               out_data, out_valid, out_last, cmd_count, err
    );

    modport slave (
        output in_data, in_dir_r, in_last, in_valid, core_zero_count, out_ready,
        input  in_ready, core_data, core_dir_r, core_step, core_clr,
               out_data, out_valid, out_last, cmd_count, err
    );
endinterface

// File: rtl/dial_cmd_sequencer.sv
// Assembles beat-streamed rotation commands, steps the dial core once per command,
// and streams the frame's zero count out as eight nibbles before clearing the core.
//
// state     | meaning
// S_INIT    | core_clr pulse, frame counters cleared
// S_COLLECT | accepting command beats
// S_ISSUE   | core_step pulse for the assembled command
// S_WAIT    | core settle latency (CORE_LAT cycles)
// S_LOAD    | capture core_zero_count into the shift register
// S_SEND    | present result nibbles, MS first
module dial_cmd_sequencer #(
    parameter int INPUT_WIDTH = 4,
    parameter int CORE_LAT    = 1
) (
    input logic                  sys_clk,
    input logic                  rst,
    dial_cmd_sequencer_if.master bus
);
    localparam int BEATS = 32 / INPUT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [3:0]    WAIT_LOAD = 4'(CORE_LAT - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_COLLECT,
        S_ISSUE,
        S_WAIT,
        S_LOAD,
        S_SEND
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [31:0]    asm_q, asm_d;
    logic           dir_cap_q, dir_cap_d;
    logic           last_flag_q, last_flag_d;
    logic [3:0]     wait_q, wait_d;
    logic [2:0]     nib_q, nib_d;
    logic [31:0]    shreg_q, shreg_d;

    logic [31:0]    core_data_q, core_data_d;
    logic           core_dir_q, core_dir_d;
    logic           core_step_q, core_step_d;
    logic           core_clr_q, core_clr_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [3:0]     out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic [15:0]    cmd_count_q, cmd_count_d;
    logic           err_q, err_d;

    logic           in_xfer;
    logic           out_xfer;

    assign in_xfer  = in_ready_q && bus.in_valid;
    assign out_xfer = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        asm_d       = asm_q;
        dir_cap_d   = dir_cap_q;
        last_flag_d = last_flag_q;
        wait_d      = wait_q;
        nib_d       = nib_q;
        shreg_d     = shreg_q;
        core_data_d = core_data_q;
        core_dir_d  = core_dir_q;
        cmd_count_d = cmd_count_q;
        err_d       = err_q;

        case (state_q)
            S_INIT: begin
                beat_d      = '0;
                cmd_count_d = '0;
                // Stay one cycle with core_clr visible before accepting beats
                if (core_clr_q) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (in_xfer) begin
                    asm_d  = {asm_q[31-INPUT_WIDTH:0], bus.in_data};
                    beat_d = beat_q + 1'b1;
                    if (beat_q == '0) begin
                        dir_cap_d = bus.in_dir_r;
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d      = '0;
                        core_data_d = asm_d;
                        core_dir_d  = dir_cap_q;
                        last_flag_d = bus.in_last;
                        state_d     = S_ISSUE;
                    end else if (bus.in_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_count_q != 16'hFFFF) begin
                    cmd_count_d = cmd_count_q + 16'd1;
                end
                wait_d  = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = last_flag_q ? S_LOAD : S_COLLECT;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_LOAD: begin
                shreg_d = bus.core_zero_count;
                nib_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_xfer) begin
                    shreg_d = {shreg_q[27:0], 4'h0};
                    nib_d   = nib_q + 3'd1;
                    if (nib_q == 3'd7) begin
                        state_d = S_INIT;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Registered Moore-style outputs follow the state being entered
        core_clr_d  = (state_d == S_INIT);
        core_step_d = (state_d == S_ISSUE);
        in_ready_d  = (state_d == S_COLLECT);
        out_valid_d = (state_d == S_SEND);
        out_data_d  = (state_d == S_SEND) ? shreg_d[31:28] : 4'h0;
        out_last_d  = (state_d == S_SEND) && (nib_d == 3'd7);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            beat_q      <= '0;
            asm_q       <= '0;
            dir_cap_q   <= 1'b0;
            last_flag_q <= 1'b0;
            wait_q      <= '0;
            nib_q       <= '0;
            shreg_q     <= '0;
            core_data_q <= '0;
            core_dir_q  <= 1'b0;
            core_step_q <= 1'b0;
            core_clr_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            cmd_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            asm_q       <= asm_d;
            dir_cap_q   <= dir_cap_d;
            last_flag_q <= last_flag_d;
            wait_q      <= wait_d;
            nib_q       <= nib_d;
            shreg_q     <= shreg_d;
            core_data_q <= core_data_d;
            core_dir_q  <= core_dir_d;
            core_step_q <= core_step_d;
            core_clr_q  <= core_clr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            cmd_count_q <= cmd_count_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.core_data  = core_data_q;
    assign bus.core_dir_r = core_dir_q;
    assign bus.core_step  = core_step_q;
    assign bus.core_clr   = core_clr_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.cmd_count  = cmd_count_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_dial_cmd_sequencer.sv
// Scoreboard bench for dial_cmd_sequencer: expected core steps and result nibbles
// are queued as stimulus is driven and checked as the sequencer produces them.
module tb_dial_cmd_sequencer;
    localparam int CORE_LAT = 2;

    logic sys_clk;
    logic rst;

    dial_cmd_sequencer_if #(.INPUT_WIDTH(4)) bus ();

    dial_cmd_sequencer #(
        .INPUT_WIDTH(4),
        .CORE_LAT   (CORE_LAT)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int clr_cnt = 0;
    logic stall_mode = 1'b0;

    logic [32:0] step_q[$];
    logic [4:0]  nib_q[$];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // out_ready changes mid-high-phase so the negedge monitor sees a settled value
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph  = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            if (stall_mode) begin
                bus.out_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                bus.out_ready = 1'b1;
                ph = 0;
            end
        end
    end

    initial begin
        logic [32:0] es;
        logic [4:0]  en;
        logic        hold_pending;
        logic [3:0]  held_data;
        hold_pending = 1'b0;
        held_data    = 4'h0;
        forever begin
            @(negedge sys_clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (bus.core_step) begin
                    chk("step_expected", step_q.size() != 0, 1'b1);
                    if (step_q.size() != 0) begin
                        es = step_q.pop_front();
                        chk("core_data", bus.core_data, es[31:0]);
                        chk("core_dir_r", bus.core_dir_r, es[32]);
                    end
                end
                if (hold_pending) begin
                    chk("hold_valid", bus.out_valid, 1'b1);
                    chk("hold_data", bus.out_data, held_data);
                end
                hold_pending = bus.out_valid && !bus.out_ready;
                held_data    = bus.out_data;
                if (bus.out_valid && bus.out_ready) begin
                    chk("nib_expected", nib_q.size() != 0, 1'b1);
                    if (nib_q.size() != 0) begin
                        en = nib_q.pop_front();
                        chk("nib_data", bus.out_data, en[3:0]);
                        chk("nib_last", bus.out_last, en[4]);
                    end
                end
                if (bus.core_clr) clr_cnt++;
                if (bus.in_ready && bus.out_valid) chk("ready_valid_excl", 1'b1, 1'b0);
            end
        end
    end

    task automatic send_beat(input logic [3:0] d, input logic dir, input logic last);
        int n;
        bus.in_data  = d;
        bus.in_dir_r = dir;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        chk("beat_accept", bus.in_ready, 1'b1);
        @(negedge sys_clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic push_result(input logic [31:0] val);
        bus.core_zero_count = val;
        for (int i = 0; i < 8; i++) begin
            nib_q.push_back({(i == 7), val[31-4*i -: 4]});
        end
    endtask

    // last_idx: beat carrying in_last (-1 for none); frame_end: expect a result phase
    task automatic send_cmd(input logic [31:0] val, input logic dir, input int last_idx,
                            input int gap_max, input logic frame_end, input int exp_cnt);
        int n;
        step_q.push_back({dir, val});
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge sys_clk);
            send_beat(val[31-4*i -: 4], (i == 0) ? dir : ~dir, (i == last_idx));
        end
        chk("step_timing", bus.core_step, 1'b1);
        n = 0;
        if (!frame_end) begin
            while (!bus.in_ready && n < 50) begin
                @(negedge sys_clk);
                n++;
            end
            chk("ready_gap", n, CORE_LAT + 1);
        end else begin
            while (!bus.out_valid && n < 50) begin
                @(negedge sys_clk);
                n++;
            end
            chk("out_latency", n, CORE_LAT + 2);
            chk("cmd_count", bus.cmd_count, exp_cnt);
        end
    endtask

    task automatic finish_frame();
        int n;
        int clr_start;
        clr_start = clr_cnt;
        n = 0;
        while (nib_q.size() != 0 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        chk("nib_drain", nib_q.size(), 0);
        repeat (3) @(negedge sys_clk);
        chk("clr_pulses", clr_cnt - clr_start, 1);
        chk("ready_after_clr", bus.in_ready, 1'b1);
        chk("valid_after_send", bus.out_valid, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.in_data = '0;
        bus.in_dir_r = 1'b0;
        bus.in_last = 1'b0;
        bus.in_valid = 1'b0;
        bus.core_zero_count = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_core_clr", bus.core_clr, 1'b0);
        chk("rst_core_step", bus.core_step, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_core_data", bus.core_data, 32'h0);
        chk("rst_cmd_count", bus.cmd_count, 16'h0);
        chk("rst_err", bus.err, 1'b0);
        rst = 1'b0;
        @(negedge sys_clk);
        chk("init_clr_hi", bus.core_clr, 1'b1);
        chk("init_ready_lo", bus.in_ready, 1'b0);
        @(negedge sys_clk);
        chk("init_clr_lo", bus.core_clr, 1'b0);
        chk("init_ready_hi", bus.in_ready, 1'b1);

        // single-command frame
        push_result(32'h12345678);
        send_cmd(32'h00000032, 1'b1, 7, 0, 1'b1, 1);
        finish_frame();

        // three commands with random valid gaps
        send_cmd(32'h00000044, 1'b0, -1, 3, 1'b0, 0);
        send_cmd(32'h00000010, 1'b1, -1, 3, 1'b0, 0);
        push_result(32'h0BADF00D);
        send_cmd(32'h00000005, 1'b1, 7, 3, 1'b1, 3);
        finish_frame();

        // output back-pressure
        stall_mode = 1'b1;
        push_result(32'hA5A5A5A5);
        send_cmd(32'h00000001, 1'b0, 7, 1, 1'b1, 1);
        finish_frame();
        stall_mode = 1'b0;

        // early in_last: flagged, command still issued, no result phase
        send_cmd(32'h00000ABC, 1'b1, 2, 1, 1'b0, 0);
        chk("err_set", bus.err, 1'b1);
        push_result(32'h00000002);
        send_cmd(32'h00000007, 1'b0, 7, 1, 1'b1, 2);
        finish_frame();
        chk("err_sticky", bus.err, 1'b1);

        // reset in the middle of a command
        send_beat(4'hF, 1'b0, 1'b0);
        send_beat(4'hF, 1'b0, 1'b0);
        send_beat(4'hF, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("mid_rst_err", bus.err, 1'b0);
        chk("mid_rst_ready", bus.in_ready, 1'b0);
        chk("mid_rst_cnt", bus.cmd_count, 16'h0);
        rst = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        chk("post_rst_ready", bus.in_ready, 1'b1);
        push_result(32'h87654321);
        send_cmd(32'h000000F7, 1'b1, 7, 1, 1'b1, 1);
        finish_frame();
        chk("post_rst_err", bus.err, 1'b0);

        repeat (5) @(negedge sys_clk);
        chk("step_q_empty", step_q.size(), 0);
        chk("nib_q_empty", nib_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
